sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester access controller for the single-port synchronous SRAM in the CPU MMU. It arbitrates between the instruction-fetch port (port 0) and the load/store port (port 1) and sequences each access as a one-cycle SRAM command. It returns read data or a write acknowledge to the winning port and rejects out-of-range addresses without touching the array. Sits between the CPU pipeline front/back ends and `sram`.

## Interface

- `ADDRESS`, 20: address width, shared with the SRAM.
- `DATA`, 8: data word width.
- `DEPTH`, 20: number of implemented words; legal addresses are 0..DEPTH-1.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `pN_req_valid` in 1 (N=0,1): port N has a request.
- `pN_req_ready` out 1: request accepted this cycle.
- `pN_req_write` in 1: 1 = write, 0 = read.
- `pN_req_addr` in ADDRESS: word address.
- `pN_req_wdata` in DATA: write data.
- `pN_rsp_valid` out 1: one-cycle response pulse.
- `pN_rsp_rdata` out DATA: read data while rsp_valid; 0 otherwise.
- `pN_rsp_err` out 1: address ≥ DEPTH; qualified by rsp_valid.
- `sram_chip_select` out 1, `sram_read` out 1, `sram_write` out 1: SRAM command.
- `sram_addr` out ADDRESS, `sram_data_in` out DATA: SRAM address and write data.
- `sram_data_out` in DATA: SRAM registered read data.

## Operation

- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: the arbiter picks one valid port and asserts its `req_ready` (combinational from the valids and the priority pointer). On handshake, latch write, addr, wdata, port id, and `err = (addr >= DEPTH)`, then go to ACCESS. With no valid request, stay in IDLE.
- Arbitration is round-robin:
  - With one port valid, that port wins.
  - With both valid, the port not granted last wins.
  - `last_grant` resets to 0, so port 1 wins the first tie.
  - `last_grant` updates only on a handshake.
- ACCESS, lasting exactly one cycle:
  - If not err: `sram_chip_select`=1, `sram_read`=!write, `sram_write`=write, and addr/data driven from the latched request.
  - If err: all SRAM strobes stay 0.
  - Next state is RESP.
- RESP, lasting exactly one cycle:
  - Pulse `rsp_valid` on the latched port only.
  - `rsp_rdata` = `sram_data_out` for a legal read, else 0.
  - `rsp_err` = latched err.
  - Next state is IDLE.
- Outside ACCESS, all SRAM outputs are 0. `sram_read` and `sram_write` are never both 1.
- `req_ready` is 0 in ACCESS and RESP. Requesters hold `req_*` stable until ready.
- Responses have no back-pressure; requesters must accept `rsp_valid`.
- Address compare is unsigned at full ADDRESS width.

## Timing

- Handshake in cycle T, SRAM strobe in T+1, `rsp_valid` in T+2, next handshake possible in T+3.
- Fixed latency: 2 cycles from handshake to response. Throughput: 1 access per 3 cycles.
- Erroneous requests have the same latency as legal ones.
- Reset values: all `req_ready`, `rsp_valid`, `rsp_err`, `rsp_rdata` and all `sram_*` outputs are 0. State is IDLE, `last_grant`=0, latched request is cleared.
- Reset asserted in ACCESS or RESP: the in-flight transaction is dropped, with no response and no further strobe. An SRAM write already strobed in ACCESS may have completed.
- A request that deasserts valid without a handshake is forgotten. No state is kept per port.

## Structure

- `sram_arbiter_pkg`: state enum (IDLE, ACCESS, RESP) and port-id constants `PORT_IFETCH`=0, `PORT_LSU`=1.
- Sub-module `rr_arbiter2`: inputs req[1:0], grant_taken; output one-hot gnt[1:0]; owns `last_grant`. The rest of the block (FSM, request latch, SRAM drive, response mux) lives in the top module.

## Test plan

- Reset, then p1 write addr 5 data 0xA5, then p0 read addr 5 -> write strobe one cycle after handshake; p0 `rsp_valid` 2 cycles after its handshake with rdata 0xA5 and err 0.
- p0 and p1 read valid continuously from reset -> grants alternate p1, p0, p1, p0; handshakes 3 cycles apart; each response reaches only the granted port.
- p0 read addr 20 (DEPTH=20) -> no SRAM strobe; p0 `rsp_valid` with err=1 and rdata 0 at T+2; the next request is serviced normally.
- Only p0 valid for 4 requests -> p0 granted every time with no idle gaps beyond the 3-cycle cadence.
- `rst` asserted during ACCESS of a p1 read -> no `rsp_valid` follows; all outputs are 0 the cycle after reset; the first post-reset tie grants p1.
- Throughout random traffic: `sram_read` and `sram_write` are never both 1; `chip_select` is only active in ACCESS; `req_ready` is at most one-hot.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the SRAM access arbiter: controller states and requester ids.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_IFETCH = 1'b0;
  localparam logic PORT_LSU    = 1'b1;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the port that did not win the last accepted grant.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       grant_taken,
  output logic [1:0] gnt
);

  logic r_lastGrant;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastGrant <= PORT_IFETCH;
    end else if (grant_taken) begin
      r_lastGrant <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_lastGrant == PORT_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates instruction-fetch and load/store ports onto a single-port SRAM,
// one access per three cycles: accept, strobe, respond.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDRESS = 20,
  parameter int DATA    = 8,
  parameter int DEPTH   = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               p0_req_valid,
  output logic               p0_req_ready,
  input  logic               p0_req_write,
  input  logic [ADDRESS-1:0] p0_req_addr,
  input  logic [DATA-1:0]    p0_req_wdata,
  output logic               p0_rsp_valid,
  output logic [DATA-1:0]    p0_rsp_rdata,
  output logic               p0_rsp_err,
  input  logic               p1_req_valid,
  output logic               p1_req_ready,
  input  logic               p1_req_write,
  input  logic [ADDRESS-1:0] p1_req_addr,
  input  logic [DATA-1:0]    p1_req_wdata,
  output logic               p1_rsp_valid,
  output logic [DATA-1:0]    p1_rsp_rdata,
  output logic               p1_rsp_err,
  output logic               sram_chip_select,
  output logic               sram_read,
  output logic               sram_write,
  output logic [ADDRESS-1:0] sram_addr,
  output logic [DATA-1:0]    sram_data_in,
  input  logic [DATA-1:0]    sram_data_out
);

  localparam logic [ADDRESS-1:0] LP_DEPTH = ADDRESS'(DEPTH);

  state_t               r_state;
  state_t               w_nextState;
  logic                 r_write;
  logic [ADDRESS-1:0]   r_addr;
  logic [DATA-1:0]      r_wdata;
  logic                 r_port;
  logic                 r_err;
  logic [1:0]           w_gnt;
  logic [1:0]           w_arbReq;
  logic                 w_handshake;
  logic                 w_selWrite;
  logic [ADDRESS-1:0]   w_selAddr;
  logic [DATA-1:0]      w_selWdata;
  logic [DATA-1:0]      w_rspData;

  // Requests are only offered to the arbiter while idle and out of reset,
  // so a grant is always a completed handshake.
  assign w_arbReq    = {p1_req_valid, p0_req_valid} & {2{(r_state == IDLE) && !rst}};
  assign w_handshake = |w_gnt;

  rr_arbiter2 u_rrArbiter (
    .clk         (clk),
    .rst         (rst),
    .req         (w_arbReq),
    .grant_taken (w_handshake),
    .gnt         (w_gnt)
  );

  assign w_selWrite = w_gnt[1] ? p1_req_write : p0_req_write;
  assign w_selAddr  = w_gnt[1] ? p1_req_addr  : p0_req_addr;
  assign w_selWdata = w_gnt[1] ? p1_req_wdata : p0_req_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_port  <= PORT_IFETCH;
      r_err   <= 1'b0;
    end else if (w_handshake) begin
      r_write <= w_selWrite;
      r_addr  <= w_selAddr;
      r_wdata <= w_selWdata;
      r_port  <= w_gnt[1];
      r_err   <= (w_selAddr >= LP_DEPTH);
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_nextState = ACCESS;
      ACCESS:  w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Out-of-range requests still walk through ACCESS, just without strobes,
  // keeping error latency identical to a legal access.
  assign w_rspData = (!r_err && !r_write) ? sram_data_out : '0;

  always_comb begin
    p0_req_ready     = w_gnt[0];
    p1_req_ready     = w_gnt[1];
    sram_chip_select = 1'b0;
    sram_read        = 1'b0;
    sram_write       = 1'b0;
    sram_addr        = '0;
    sram_data_in     = '0;
    p0_rsp_valid     = 1'b0;
    p0_rsp_rdata     = '0;
    p0_rsp_err       = 1'b0;
    p1_rsp_valid     = 1'b0;
    p1_rsp_rdata     = '0;
    p1_rsp_err       = 1'b0;
    if (r_state == ACCESS && !r_err) begin
      sram_chip_select = 1'b1;
      sram_read        = !r_write;
      sram_write       = r_write;
      sram_addr        = r_addr;
      sram_data_in     = r_wdata;
    end
    if (r_state == RESP) begin
      if (r_port == PORT_LSU) begin
        p1_rsp_valid = 1'b1;
        p1_rsp_rdata = w_rspData;
        p1_rsp_err   = r_err;
      end else begin
        p0_rsp_valid = 1'b1;
        p0_rsp_rdata = w_rspData;
        p0_rsp_err   = r_err;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: an SRAM model, a transaction-level
// reference model compared every cycle, and directed scenarios with literal checks.
module tb_sram_arbiter;

  localparam int ADDRESS = 20;
  localparam int DATA    = 8;
  localparam int DEPTH   = 20;

  logic               clk = 1'b0;
  logic               rst;
  logic               p0_req_valid, p0_req_ready, p0_req_write;
  logic [ADDRESS-1:0] p0_req_addr;
  logic [DATA-1:0]    p0_req_wdata, p0_rsp_rdata;
  logic               p0_rsp_valid, p0_rsp_err;
  logic               p1_req_valid, p1_req_ready, p1_req_write;
  logic [ADDRESS-1:0] p1_req_addr;
  logic [DATA-1:0]    p1_req_wdata, p1_rsp_rdata;
  logic               p1_rsp_valid, p1_rsp_err;
  logic               sram_chip_select, sram_read, sram_write;
  logic [ADDRESS-1:0] sram_addr;
  logic [DATA-1:0]    sram_data_in;
  logic [DATA-1:0]    sram_data_out = '0;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.ADDRESS(ADDRESS), .DATA(DATA), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .sram_chip_select(sram_chip_select), .sram_read(sram_read), .sram_write(sram_write),
    .sram_addr(sram_addr), .sram_data_in(sram_data_in), .sram_data_out(sram_data_out)
  );

  always #5 clk = ~clk;

  // SRAM with registered read data, as seen by the arbiter.
  logic [DATA-1:0] sramMem [DEPTH];
  always @(posedge clk) begin
    if (sram_chip_select && sram_addr < ADDRESS'(DEPTH)) begin
      if (sram_write) sramMem[sram_addr] <= sram_data_in;
      if (sram_read)  sram_data_out <= sramMem[sram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction accepted in cycle T strobes at T+1,
  // responds at T+2 and frees the controller from T+3 on.
  logic [DATA-1:0] refMem [DEPTH];
  int   cyc = 0;
  bit   mTxn = 0;
  int   mHs = 0;
  logic mPort, mWrite, mErr, mLast = 1'b0;
  logic [ADDRESS-1:0] mAddr;
  logic [DATA-1:0]    mWdata, mData;
  int   gPort[$];
  int   gCyc[$];
  int   rsp0Count = 0, rsp1Count = 0, rsp0Cyc = 0, lastWrCyc = -1;
  logic [DATA-1:0] rsp0Data;
  logic rsp0Err;

  always @(negedge clk) begin
    bit free;
    logic win;
    logic [1:0] eReady;
    logic [30:0] eSram;
    logic [1:0] eV, eE;
    logic [DATA-1:0] eD0, eD1;
    free = !mTxn || (cyc >= mHs + 3);
    eReady = 2'b00;
    win = 1'b0;
    if (free && !rst && (p0_req_valid || p1_req_valid)) begin
      win = (p0_req_valid && p1_req_valid) ? !mLast : p1_req_valid;
      eReady[win] = 1'b1;
    end
    eSram = '0;
    if (mTxn && cyc == mHs + 1 && !mErr) eSram = {1'b1, !mWrite, mWrite, mAddr, mWdata};
    eV = 2'b00; eE = 2'b00; eD0 = '0; eD1 = '0;
    if (mTxn && cyc == mHs + 2) begin
      eV[mPort] = 1'b1;
      eE[mPort] = mErr;
      if (mPort) eD1 = (!mErr && !mWrite) ? mData : '0;
      else       eD0 = (!mErr && !mWrite) ? mData : '0;
    end
    checkOutput("req_ready", {p1_req_ready, p0_req_ready}, eReady);
    checkOutput("sram_cmd", {sram_chip_select, sram_read, sram_write, sram_addr, sram_data_in}, eSram);
    checkOutput("rsp", {p1_rsp_valid, p0_rsp_valid, p1_rsp_valid & p1_rsp_err,
                        p0_rsp_valid & p0_rsp_err, p1_rsp_rdata, p0_rsp_rdata},
                {eV, eE, eD1, eD0});
    checkOutput("rd_wr_exclusive", sram_read & sram_write, 0);
    checkOutput("ready_onehot", p0_req_ready & p1_req_ready, 0);
    if (p0_rsp_valid) begin
      rsp0Count++; rsp0Cyc = cyc; rsp0Data = p0_rsp_rdata; rsp0Err = p0_rsp_err;
    end
    if (p1_rsp_valid) rsp1Count++;
    if (sram_write) lastWrCyc = cyc;
    if (rst) begin
      mTxn = 0;
      mLast = 1'b0;
    end else if (eReady != 2'b00) begin
      mTxn = 1; mHs = cyc; mPort = win; mLast = win;
      mWrite = win ? p1_req_write : p0_req_write;
      mAddr  = win ? p1_req_addr  : p0_req_addr;
      mWdata = win ? p1_req_wdata : p0_req_wdata;
      mErr   = (mAddr >= ADDRESS'(DEPTH));
      if (!mErr) begin
        if (mWrite) refMem[mAddr] = mWdata;
        else        mData = refMem[mAddr];
      end
      gPort.push_back(int'(win));
      gCyc.push_back(cyc);
    end
    cyc++;
  end

  // Drive one request and hold it until accepted; drops valid in the following cycle.
  task automatic applyStimulus(input int port, input logic wr, input int addr, input int wdata);
    bit got = 0;
    @(posedge clk); #1;
    if (port == 0) begin
      p0_req_valid = 1'b1; p0_req_write = wr;
      p0_req_addr = ADDRESS'(addr); p0_req_wdata = DATA'(wdata);
    end else begin
      p1_req_valid = 1'b1; p1_req_write = wr;
      p1_req_addr = ADDRESS'(addr); p1_req_wdata = DATA'(wdata);
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? p0_req_ready : p1_req_ready;
    end
    if (!got) begin
      errors++;
      $display("[TB] FAIL handshake_timeout port=%0d actual=0 required=1", port);
    end
    @(posedge clk); #1;
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
  endtask

  task automatic waitGrants(input int target);
    for (int i = 0; i < 40 && gPort.size() < target; i++) @(negedge clk);
    checkOutput("grant_count", gPort.size(), target);
  endtask

  initial begin
    int n0;
    logic r0, r1;
    for (int i = 0; i < DEPTH; i++) begin
      sramMem[i] = DATA'(i * 7 + 3);
      refMem[i]  = DATA'(i * 7 + 3);
    end
    rst = 1'b1;
    p0_req_valid = 0; p0_req_write = 0; p0_req_addr = '0; p0_req_wdata = '0;
    p1_req_valid = 0; p1_req_write = 0; p1_req_addr = '0; p1_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] write via p1, read back via p0");
    applyStimulus(1, 1'b1, 5, 8'hA5);
    applyStimulus(0, 1'b0, 5, 0);
    repeat (3) @(negedge clk);
    checkOutput("wr_strobe_latency", lastWrCyc - gCyc[0], 1);
    checkOutput("rd_rsp_latency", rsp0Cyc - gCyc[1], 2);
    checkOutput("rd_data_a5", rsp0Data, 8'hA5);
    checkOutput("rd_err_0", rsp0Err, 0);

    $display("[TB] both ports reading continuously");
    n0 = gPort.size();
    @(posedge clk); #1;
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 1;
    p1_req_valid = 1; p1_req_write = 0; p1_req_addr = 2;
    waitGrants(n0 + 4);
    @(posedge clk); #1;
    p0_req_valid = 0; p1_req_valid = 0;
    for (int i = 0; i < 4; i++) checkOutput("alt_grant", gPort[n0 + i], (i % 2 == 0) ? 1 : 0);
    checkOutput("alt_spacing", gCyc[n0 + 3] - gCyc[n0], 9);
    repeat (3) @(negedge clk);

    $display("[TB] out-of-range read then legal read");
    applyStimulus(0, 1'b0, 20, 0);
    repeat (3) @(negedge clk);
    checkOutput("oor_err", rsp0Err, 1);
    checkOutput("oor_rdata", rsp0Data, 0);
    applyStimulus(0, 1'b0, 5, 0);
    repeat (3) @(negedge clk);
    checkOutput("post_oor_data", {rsp0Err, rsp0Data}, {1'b0, 8'hA5});

    $display("[TB] p0 alone back to back");
    n0 = gPort.size();
    @(posedge clk); #1;
    p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 7;
    waitGrants(n0 + 4);
    @(posedge clk); #1;
    p0_req_valid = 0;
    for (int i = 0; i < 4; i++) checkOutput("solo_grant", gPort[n0 + i], 0);
    checkOutput("solo_spacing", gCyc[n0 + 3] - gCyc[n0], 9);
    repeat (3) @(negedge clk);

    $display("[TB] reset during ACCESS of a p1 read");
    n0 = rsp1Count;
    applyStimulus(1, 1'b0, 3, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_outputs", {p0_req_ready, p1_req_ready, sram_chip_select, sram_read,
                sram_write, sram_addr, sram_data_in, p0_rsp_valid, p1_rsp_valid,
                p0_rsp_rdata, p1_rsp_rdata, p0_rsp_err, p1_rsp_err}, 0);
    repeat (3) @(negedge clk);
    checkOutput("no_rsp_after_reset", rsp1Count, n0);
    n0 = gPort.size();
    @(posedge clk); #1;
    p0_req_valid = 1; p1_req_valid = 1; p0_req_addr = 4; p1_req_addr = 6;
    waitGrants(n0 + 1);
    @(posedge clk); #1;
    p0_req_valid = 0; p1_req_valid = 0;
    checkOutput("first_tie_after_reset", gPort[n0], 1);
    repeat (3) @(negedge clk);

    $display("[TB] random traffic");
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      r0 = p0_req_ready; r1 = p1_req_ready;
      @(posedge clk); #1;
      if (!p0_req_valid || r0) begin
        p0_req_valid = 1'($urandom_range(0, 1)); p0_req_write = 1'($urandom_range(0, 1));
        p0_req_addr = ADDRESS'($urandom_range(0, 23)); p0_req_wdata = DATA'($urandom_range(0, 255));
      end
      if (!p1_req_valid || r1) begin
        p1_req_valid = 1'($urandom_range(0, 1)); p1_req_write = 1'($urandom_range(0, 1));
        p1_req_addr = ADDRESS'($urandom_range(0, 23)); p1_req_wdata = DATA'($urandom_range(0, 255));
      end
    end
    @(negedge clk);
    r0 = p0_req_ready; r1 = p1_req_ready;
    @(posedge clk); #1;
    p0_req_valid = 0; p1_req_valid = 0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
